mem_subword_ctrl: RTL and testbench
===================================

// Module: mem_subword_ctrl
// PURPOSE
//  Multi-cycle sequencer between the CPU datapath and a word-wide synchronous data RAM.
//  Runs LB/LBU/LH/LHU/LW and SB/SH/SW from the decoder's Mode/Memwrite/Signedext controls.
//  Sub-word stores use read-modify-write; loads extract and extend the addressed lane.
//  Holds `busy` high so the PC/pipeline stalls until `done`.
// PARAMETERS
//  ADDR_W  10  word-address width of the RAM; mem_addr = addr[ADDR_W+1:2]
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  req        in   1       access request; sampled only in IDLE
//  we         in   1       1 = store, 0 = load
//  mode       in   2       00 byte, 01 half, 10 word, 11 reserved (error)
//  sext       in   1       loads: 1 = sign-extend (LB/LH), 0 = zero-extend (LBU/LHU)
//  addr       in   32      byte address
//  wdata      in   32      store data; byte/half taken from bits [7:0]/[15:0]
//  busy       out  1       state != IDLE
//  done       out  1       one-cycle pulse; access complete
//  err        out  1       valid with done; misaligned or reserved mode
//  rdata      out  32      load result; valid with done, held until next done
//  mem_addr   out  ADDR_W  RAM word address
//  mem_re     out  1       RAM read strobe; mem_rdata valid the following cycle
//  mem_we     out  1       RAM write strobe
//  mem_wdata  out  32      RAM write word
//  mem_rdata  in   32      RAM read data
//  mem_be     out  4       byte enables (present only with MEM_BE_EN)
// BEHAVIOUR
//  - Reset (async): state=IDLE; busy, done, err, mem_re, mem_we = 0; rdata, mem_addr, mem_wdata = 0.
//  - Reset mid-access: mem_we drops immediately; the in-flight store is abandoned and the RAM is not written.
//  - Accept: in IDLE with req=1, latch we/mode/sext/addr/wdata. req is ignored while busy.
//  - Memory-side outputs decode from state and latched regs only; no combinational path from req.
//  - Little-endian lanes: offset 0 = bits[7:0]; half at addr[1]=0 = bits[15:0].
//  - Alignment: half requires addr[0]=0; word requires addr[1:0]=00.
//  - States IDLE, RD, WAIT, WR, RESP:
//    IDLE->RESP (err=1, no RAM access): misaligned address or mode=11.
//    IDLE->WR: word store.
//    IDLE->RD: loads and sub-word stores.
//    RD: mem_re=1 -> WAIT.
//    WAIT, load: extract and extend the lane into rdata -> RESP.
//    WAIT, store: merge wdata lane into mem_rdata, register the result -> WR.
//    WR: mem_we=1 with merged (or full) word -> RESP.
//    RESP: done=1 -> IDLE. Next req is accepted the cycle after RESP.
//  - Latency in cycles after the accept cycle: error 1, SW 2, loads 3, SB/SH 4.
//  - On err, rdata keeps its previous value.
// CONFIGURATION
//  MEM_BE_EN defined: mem_be port exists; all stores go IDLE->WR (no RMW, latency 2).
//    Lane data is replicated: byte x4, half x2.
//    mem_be = lane mask during WR: SB 0001<<addr[1:0]; SH 0011 or 1100; SW 1111.
//    mem_be = 0000 otherwise.
//  MEM_BE_EN undefined: no mem_be port; sub-word stores use RMW as above.
// TESTING
//  - RAM[0]=0x80FF7F01; LB addr 0x2 sext=1 -> rdata 0xFFFFFFFF; LBU -> 0x000000FF.
//    Both: done 3 cycles after req, err=0.
//  - RAM[1]=0x11223344; SB addr 0x5 wdata 0xAB -> RAM[1]=0x1122AB44.
//    mem_re 1 cycle, mem_we 1 cycle, done at cycle 4.
//  - LH addr 0x3 -> done at cycle 1 with err=1; mem_re and mem_we never assert; rdata unchanged.
//  - req held high through a LW -> second access starts only after RESP.
//    busy stays 1 throughout; exactly one done per access.
//  - rst_n=0 during WR of SW 0xDEADBEEF to addr 0x8 -> mem_we=0 at once; RAM[2] unchanged.
//    After release: busy=0, done=0.
//  - MEM_BE_EN: SH addr 0x6 wdata 0x0000BEEF -> mem_be=1100, mem_wdata=0xBEEFBEEF.
//    No mem_re; done at cycle 2.

Source files
------------

// File: rtl/mem_subword_ctrl_if.sv
`default_nettype none
//==============================================================================
// Module   : mem_subword_ctrl_if
// Brief    : CPU-side request/response bundle for the sub-word memory
//            sequencer. The master (CPU datapath) issues requests; the slave
//            (sequencer) returns busy/done/err/rdata.
// Revision : 1.0 - initial release
//==============================================================================
interface mem_subword_ctrl_if;
    logic        req;
    logic        we;
    logic [1:0]  mode;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;

    modport master (
        output req, we, mode, sext, addr, wdata,
        input  busy, done, err, rdata
    );

    modport slave (
        input  req, we, mode, sext, addr, wdata,
        output busy, done, err, rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_subword_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : mem_subword_ctrl
// Brief    : Multi-cycle sequencer between the CPU datapath and a word-wide
//            synchronous RAM. Executes LB/LBU/LH/LHU/LW and SB/SH/SW; sub-word
//            stores use read-modify-write, loads extract and extend the lane.
//            busy stalls the pipeline until the one-cycle done pulse.
// Options  : MEM_BE_EN - adds the mem_be byte-enable port; every store is
//            written directly with lane data replicated across the word.
// Revision : 1.0 - initial release
//==============================================================================
module mem_subword_ctrl #(
    parameter int ADDR_W = 10
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    mem_subword_ctrl_if.slave      cpu,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic                   mem_re,
    output logic                   mem_we,
    output logic [31:0]            mem_wdata,
    input  wire logic [31:0]       mem_rdata
`ifdef MEM_BE_EN
    ,
    output logic [3:0]             mem_be
`endif
);

    localparam logic [1:0] c_MODE_BYTE = 2'b00;
    localparam logic [1:0] c_MODE_HALF = 2'b01;
    localparam logic [1:0] c_MODE_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_we;
    logic        r_sext;
    logic [1:0]  r_mode;
    logic [1:0]  r_off;
    logic [15:0] r_wdata;

    logic        w_req_err;
    logic        w_direct_wr;
    logic [31:0] w_wr_data;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merge;

    // Address bits above the RAM window are intentionally ignored
    logic        w_unused_addr;
    assign w_unused_addr = ^cpu.addr[31:ADDR_W+2];

    // Reject reserved mode and misaligned half/word accesses at accept time
    always_comb begin
        w_req_err = 1'b0;
        case (cpu.mode)
            c_MODE_BYTE: w_req_err = 1'b0;
            c_MODE_HALF: w_req_err = cpu.addr[0];
            c_MODE_WORD: w_req_err = |cpu.addr[1:0];
            default:     w_req_err = 1'b1;
        endcase
    end

`ifdef MEM_BE_EN
    logic [3:0] w_wr_be;

    // Every store is a direct write: replicate the lane, the RAM masks it
    always_comb begin
        w_direct_wr = cpu.we;
        w_wr_data   = cpu.wdata;
        w_wr_be     = 4'b1111;
        case (cpu.mode)
            c_MODE_BYTE: begin
                w_wr_data = {4{cpu.wdata[7:0]}};
                w_wr_be   = 4'b0001 << cpu.addr[1:0];
            end
            c_MODE_HALF: begin
                w_wr_data = {2{cpu.wdata[15:0]}};
                w_wr_be   = cpu.addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // Byte-enable mask is only non-zero alongside the write strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mem_be <= 4'b0000;
        else if (r_state == ST_IDLE && cpu.req && !w_req_err && cpu.we)
            mem_be <= w_wr_be;
        else if (r_state == ST_WR)
            mem_be <= 4'b0000;
    end
`else
    // Only a full-word store can skip reading the old word
    always_comb begin
        w_direct_wr = cpu.we && (cpu.mode == c_MODE_WORD);
        w_wr_data   = cpu.wdata;
    end
`endif

    // Lane extraction and sign/zero extension of the returned RAM word
    always_comb begin
        w_byte = 8'h00;
        case (r_off)
            2'd0: w_byte = mem_rdata[7:0];
            2'd1: w_byte = mem_rdata[15:8];
            2'd2: w_byte = mem_rdata[23:16];
            2'd3: w_byte = mem_rdata[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_mode)
            c_MODE_BYTE: w_load = {{24{r_sext & w_byte[7]}}, w_byte};
            c_MODE_HALF: w_load = {{16{r_sext & w_half[15]}}, w_half};
            default:     w_load = mem_rdata;
        endcase
    end

    // Merge the stored lane into the word read back from RAM
    always_comb begin
        w_merge = mem_rdata;
        if (r_mode == c_MODE_BYTE) begin
            case (r_off)
                2'd0: w_merge[7:0]   = r_wdata[7:0];
                2'd1: w_merge[15:8]  = r_wdata[7:0];
                2'd2: w_merge[23:16] = r_wdata[7:0];
                2'd3: w_merge[31:24] = r_wdata[7:0];
                default: ;
            endcase
        end else if (r_mode == c_MODE_HALF) begin
            if (r_off[1])
                w_merge[31:16] = r_wdata;
            else
                w_merge[15:0]  = r_wdata;
        end
    end

    // Access sequencer; all CPU- and RAM-side outputs are registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_we      <= 1'b0;
            r_sext    <= 1'b0;
            r_mode    <= 2'b00;
            r_off     <= 2'b00;
            r_wdata   <= 16'h0000;
            cpu.busy  <= 1'b0;
            cpu.done  <= 1'b0;
            cpu.err   <= 1'b0;
            cpu.rdata <= 32'h0000_0000;
            mem_addr  <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= 32'h0000_0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cpu.req) begin
                        r_we     <= cpu.we;
                        r_sext   <= cpu.sext;
                        r_mode   <= cpu.mode;
                        r_off    <= cpu.addr[1:0];
                        r_wdata  <= cpu.wdata[15:0];
                        mem_addr <= cpu.addr[ADDR_W+1:2];
                        cpu.busy <= 1'b1;
                        if (w_req_err) begin
                            cpu.done <= 1'b1;
                            cpu.err  <= 1'b1;
                            r_state  <= ST_RESP;
                        end else if (w_direct_wr) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= w_wr_data;
                            r_state   <= ST_WR;
                        end else begin
                            mem_re  <= 1'b1;
                            r_state <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    mem_re  <= 1'b0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_we) begin
                        mem_wdata <= w_merge;
                        mem_we    <= 1'b1;
                        r_state   <= ST_WR;
                    end else begin
                        cpu.rdata <= w_load;
                        cpu.done  <= 1'b1;
                        cpu.err   <= 1'b0;
                        r_state   <= ST_RESP;
                    end
                end
                ST_WR: begin
                    mem_we   <= 1'b0;
                    cpu.done <= 1'b1;
                    cpu.err  <= 1'b0;
                    r_state  <= ST_RESP;
                end
                ST_RESP: begin
                    cpu.done <= 1'b0;
                    cpu.err  <= 1'b0;
                    cpu.busy <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_subword_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Module   : tb_mem_subword_ctrl
// Brief    : Self-checking bench for mem_subword_ctrl. A word/byte-level model
//            predicts latency, strobes, write words and load results; a single
//            compare process checks the DUT on every falling edge.
// Options  : MEM_BE_EN - bench follows the byte-enable build of the DUT.
// Revision : 1.0 - initial release
//==============================================================================
module tb_mem_subword_ctrl;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef MEM_BE_EN
    localparam bit BE_EN = 1'b1;
`else
    localparam bit BE_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mem_subword_ctrl_if bus ();

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
`ifdef MEM_BE_EN
    logic [3:0]        mem_be;
`endif

    mem_subword_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu       (bus),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef MEM_BE_EN
        ,
        .mem_be    (mem_be)
`endif
    );

    // Synchronous RAM seen by the DUT
    logic [31:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_we) begin
`ifdef MEM_BE_EN
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) ram[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
`else
            ram[mem_addr] = mem_wdata;
`endif
        end
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    // Reference model state and expectations
    logic [31:0] ref_mem [DEPTH];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cycle    = 0;
    bit          mon_en   = 1'b0;
    bit          active   = 1'b0;
    int          t_acc, exp_lat, exp_re_n, exp_we_n, exp_idx;
    bit          exp_err;
    logic [31:0] exp_rdata, rd_hold, exp_wword;
    logic [3:0]  exp_be;
    int          re_cnt, we_cnt, done_at;
    logic [31:0] last_wdata;
    logic [3:0]  last_be;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Byte-view model of a load
    function automatic logic [31:0] model_load(input logic [31:0] w, input int off,
                                               input int mode, input bit sext);
        longint v;
        if (mode == 2) return w;
        if (mode == 0) begin
            v = longint'((w >> (8*off)) % 256);
            if (sext && v >= 128) v = v - 256;
        end else begin
            v = longint'((w >> (8*off)) % 65536);
            if (sext && v >= 32768) v = v - 65536;
        end
        return v[31:0];
    endfunction

    // Byte-view model of a store into an existing word
    function automatic logic [31:0] model_store(input logic [31:0] w, input int off,
                                                input int mode, input logic [31:0] wd);
        logic [7:0] by [4];
        int n;
        n = (mode == 0) ? 1 : (mode == 1) ? 2 : 4;
        for (int i = 0; i < 4; i++) by[i] = w[8*i +: 8];
        for (int b = 0; b < n; b++) by[off+b] = wd[8*b +: 8];
        return {by[3], by[2], by[1], by[0]};
    endfunction

    // Single compare process: checks the DUT every cycle against the model
    always @(negedge clk) begin
        int el;
        if (mon_en) begin
            if (!active) begin
                re_cnt = 0;
                we_cnt = 0;
                check("idle_busy",  {31'b0, bus.busy}, 32'd0);
                check("idle_done",  {31'b0, bus.done}, 32'd0);
                check("idle_re",    {31'b0, mem_re},   32'd0);
                check("idle_we",    {31'b0, mem_we},   32'd0);
                check("idle_rdata", bus.rdata, rd_hold);
            end else begin
                el = cycle - t_acc;
                if (mem_re) begin
                    re_cnt++;
                    check("rd_addr", {22'b0, mem_addr}, exp_idx);
                end
                if (mem_we) begin
                    we_cnt++;
                    last_wdata = mem_wdata;
                    check("wr_addr",  {22'b0, mem_addr}, exp_idx);
                    check("wr_wdata", mem_wdata, exp_wword);
`ifdef MEM_BE_EN
                    last_be = mem_be;
                    check("wr_be", {28'b0, mem_be}, {28'b0, exp_be});
`endif
                end
                if (bus.done) done_at = el;
                check("busy", {31'b0, bus.busy}, 32'd1);
                check("done", {31'b0, bus.done}, {31'b0, el == exp_lat});
                if (el == exp_lat) begin
                    check("err",    {31'b0, bus.err}, {31'b0, exp_err});
                    check("rdata",  bus.rdata, exp_rdata);
                    check("re_cnt", re_cnt, exp_re_n);
                    check("we_cnt", we_cnt, exp_we_n);
                end else begin
                    check("rdata_held", bus.rdata, rd_hold);
                end
            end
        end
    end

    // One access: predict, drive, and optionally keep req high with junk while busy
    task automatic do_access(input bit we, input logic [1:0] mode, input bit sext,
                             input logic [31:0] addr, input logic [31:0] wdata, input bit hold);
        int off, m, n;
        logic [31:0] w;
        @(negedge clk); #2;
        m       = int'(mode);
        off     = int'(addr % 4);
        exp_idx = int'((addr / 4) % DEPTH);
        w       = ref_mem[exp_idx];
        exp_err = (m == 3) || (m == 1 && (addr % 2) != 0) || (m == 2 && off != 0);
        n       = (m == 0) ? 1 : (m == 1) ? 2 : 4;
        exp_rdata = rd_hold;
        exp_re_n  = 0;
        exp_we_n  = 0;
        exp_be    = 4'((((1 << n) - 1) << off) % 16);
        exp_wword = 32'h0;
        if (exp_err) begin
            exp_lat = 1;
        end else if (we) begin
            exp_we_n  = 1;
            exp_wword = model_store(w, off, m, wdata);
            if (m == 2)          exp_lat = 2;
            else if (BE_EN)      exp_lat = 2;
            else begin
                exp_lat  = 4;
                exp_re_n = 1;
            end
            if (BE_EN && m == 0) exp_wword = (wdata % 256) * 32'h0101_0101;
            if (BE_EN && m == 1) exp_wword = (wdata % 65536) * 32'h0001_0001;
            ref_mem[exp_idx] = model_store(w, off, m, wdata);
        end else begin
            exp_lat   = 3;
            exp_re_n  = 1;
            exp_rdata = model_load(w, off, m, sext);
        end
        done_at  = -1;
        bus.req  = 1'b1;
        bus.we   = we;
        bus.mode = mode;
        bus.sext = sext;
        bus.addr = addr;
        bus.wdata = wdata;
        t_acc  = cycle;
        active = 1'b1;
        for (int k = 1; k <= exp_lat; k++) begin
            @(negedge clk); #2;
            if (hold) begin
                bus.req   = 1'b1;
                bus.we    = 1'($urandom_range(1, 0));
                bus.mode  = 2'($urandom_range(3, 0));
                bus.sext  = 1'($urandom_range(1, 0));
                bus.addr  = $urandom;
                bus.wdata = $urandom;
            end else begin
                bus.req = 1'b0;
            end
        end
        active  = 1'b0;
        rd_hold = exp_rdata;
        @(negedge clk); #2;
        bus.req = 1'b0;
    endtask

    initial begin
        logic [31:0] saved;
        bus.req = 1'b0; bus.we = 1'b0; bus.mode = 2'b00; bus.sext = 1'b0;
        bus.addr = 32'h0; bus.wdata = 32'h0;
        rd_hold = 32'h0;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = $urandom;
            ref_mem[i] = ram[i];
        end
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",  {31'b0, bus.busy}, 32'd0);
        check("rst_done",  {31'b0, bus.done}, 32'd0);
        check("rst_err",   {31'b0, bus.err},  32'd0);
        check("rst_re",    {31'b0, mem_re},   32'd0);
        check("rst_we",    {31'b0, mem_we},   32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_maddr", {22'b0, mem_addr}, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        #2 rst_n = 1'b1;
        mon_en = 1'b1;

        // Directed cases with hand-computed results
        ram[0] = 32'h80FF_7F01; ref_mem[0] = 32'h80FF_7F01;
        ram[1] = 32'h1122_3344; ref_mem[1] = 32'h1122_3344;
        do_access(1'b0, 2'b00, 1'b1, 32'h2, 32'h0, 1'b0);
        check("lb_rdata", bus.rdata, 32'hFFFF_FFFF);
        check("lb_lat", done_at, 32'd3);
        do_access(1'b0, 2'b00, 1'b0, 32'h2, 32'h0, 1'b0);
        check("lbu_rdata", bus.rdata, 32'h0000_00FF);
        check("lbu_lat", done_at, 32'd3);
        do_access(1'b1, 2'b00, 1'b0, 32'h5, 32'h0000_00AB, 1'b0);
        check("sb_ram", ram[1], 32'h1122_AB44);
        check("sb_lat", done_at, BE_EN ? 32'd2 : 32'd4);
        do_access(1'b0, 2'b01, 1'b0, 32'h3, 32'h0, 1'b0);
        check("lh_mis_lat", done_at, 32'd1);
        check("lh_mis_rdata", bus.rdata, 32'h0000_00FF);
        do_access(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1'b1);
        check("lw_hold_rdata", bus.rdata, 32'h1122_AB44);
        do_access(1'b1, 2'b01, 1'b0, 32'h6, 32'h0000_BEEF, 1'b0);
        check("sh_ram", ram[1], 32'hBEEF_AB44);
`ifdef MEM_BE_EN
        check("sh_be", {28'b0, last_be}, 32'hC);
        check("sh_wdata", last_wdata, 32'hBEEF_BEEF);
        check("sh_lat", done_at, 32'd2);
`endif

        // Reset while the word store sits in WR
        mon_en = 1'b0;
        saved  = ram[2];
        @(negedge clk); #2;
        bus.req = 1'b1; bus.we = 1'b1; bus.mode = 2'b10; bus.sext = 1'b0;
        bus.addr = 32'h8; bus.wdata = 32'hDEAD_BEEF;
        @(negedge clk); #2;
        bus.req = 1'b0;
        check("rst_wr_we_before", {31'b0, mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_wr_we_drop", {31'b0, mem_we}, 32'd0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk); #2;
        check("rst_wr_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_wr_done", {31'b0, bus.done}, 32'd0);
        check("rst_wr_ram",  ram[2], saved);
        rd_hold = 32'h0;
        mon_en  = 1'b1;

        // Randomized accesses over a small window of words
        for (int t = 0; t < 250; t++) begin
            do_access(1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)),
                      1'($urandom_range(1, 0)), $urandom & 32'hFFFF_F03F,
                      $urandom, 1'($urandom_range(1, 0)));
        end

        for (int i = 0; i < 16; i++) check("ram_final", ram[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
